serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial unsigned subtractor computing `diff = a - b` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It complements the combinational adder cells in the arithmetic lab set. It is the area-minimal subtract path for datapaths that can tolerate WIDTH-cycle latency. A start/busy/done handshake sits in front of it.

## Interface
- `WIDTH`, default 8: operand and result width; legal range is ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request pulse; sampled only when the block is not busy.
- `a` input WIDTH: minuend, captured on an accepted start.
- `b` input WIDTH: subtrahend, captured on an accepted start.
- `busy` output 1: high while a subtraction is in progress.
- `done` output 1: one-cycle pulse when the result is valid.
- `diff` output WIDTH: result `a - b` mod 2^WIDTH, held until the next completion.
- `borrow` output 1: final borrow out; 1 iff a < b (unsigned).
- `ovf` output 1: exists only with `SERIAL_SUB_OVF_EN`; signed two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 loads shift registers A←a and B←b.
  - Clears the internal borrow `bin` and bit counter `cnt`.
  - Next state is RUN.
- **RUN**, once per cycle:
  - Cell: `d = A[0]^B[0]^bin`.
  - Borrow: `bout = (~A[0]&B[0]) | (~(A[0]^B[0])&bin)`.
  - A and B shift right by 1, `d` shifts into the MSB of internal register R, `bin←bout`, `cnt←cnt+1`.
  - After the WIDTH-th bit, the cycle in which `cnt` = WIDTH-1, the next state is DONE.
  - On that same edge `diff` takes the final R value (including that last `d`) and `borrow` takes that bit's `bout`.
- **DONE**
  - `done`=1 for exactly this cycle.
  - Behaves as IDLE for `start`: a start here is accepted and goes straight to RUN (back-to-back operation). Otherwise the next state is IDLE.
- `start` in RUN is ignored. The operands in flight are unaffected.
- `diff` and `borrow` change only on the completion edge. They are stable at all other times.
- Arithmetic is modular:
  - WIDTH-bit result plus a 1-bit borrow.
  - Equal operands give `diff`=0, `borrow`=0.
  - a=0, b=2^WIDTH-1 gives `diff`=1, `borrow`=1.

## Timing
- Reset:
  - `rst` high at an edge forces IDLE with `busy`=0, `done`=0, `diff`=0, `borrow`=0, `ovf`=0.
  - Internal registers, counter and `bin` are cleared.
  - `rst` overrides `start` on the same edge.
- Reset mid-RUN aborts the operation: no `done` pulse, and outputs read 0 from the next cycle.
- Latency:
  - `start` accepted at edge T, so `busy`=1 from T.
  - Result and `done`=1 appear at edge T+WIDTH. `busy` falls at that same edge.
  - `done` drops at T+WIDTH+1 unless a new start was accepted in the DONE cycle. In that case `busy` is high again from T+WIDTH+1.
- Throughput: one result per WIDTH+1 cycles with continuous `start`.
- `busy` is registered and is high exactly in the RUN state.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- **Defined**
  - Port `ovf` exists and is registered with `diff`.
  - `ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])`, using the captured operand MSBs (saved at load).
  - `ovf` resets to 0 and is held like `diff`.
- **Undefined**
  - Port `ovf` and its MSB capture registers are absent.
  - All other behaviour is identical.

## Test plan
WIDTH=8 for all cases; benches drive `start` for exactly one cycle unless stated.

1. Hold `rst`=1 for 2 cycles with `start`=1 → `busy`=0, `done`=0, `diff`=0x00, `borrow`=0, `ovf`=0; the FSM stays IDLE.
2. a=0x5A, b=0x1F, start at edge T → `busy` is high for edges T..T+7, `done`=1 only in the cycle after edge T+8, `diff`=0x3B, `borrow`=0, `ovf`=0.
3. a=0x10, b=0x20 → `diff`=0xF0, `borrow`=1, `ovf`=0. Then a=0x80, b=0x01 → `diff`=0x7F, `borrow`=0, `ovf`=1.
4. a=0x33, b=0x11 started, then `start` pulsed 3 cycles later with a=0xFF, b=0xFF → the second start is ignored; completion gives `diff`=0x22, and no second `done` follows.
5. `start` held continuously with a=0x05, b=0x07 → `done` pulses every 9 cycles, each with `diff`=0xFE, `borrow`=1; `diff` is stable between pulses.
6. a=0x40, b=0x01 started, `rst`=1 for one cycle after 4 RUN cycles → the next cycle shows `busy`=0, `diff`=0x00, `borrow`=0, and no `done` pulse ever appears for the aborted operation.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: start, a and b go in, busy, done and the result come back.
// The ovf wire and its modport entries exist only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, through one full-subtractor cell; the result and done arrive WIDTH cycles after an accepted start.
// start is ignored while busy; SERIAL_SUB_OVF_EN adds a registered signed-overflow flag.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;

  logic             d;
  logic             bout;
  logic             last;
  logic [WIDTH-1:0] r_nxt;

  always_comb begin
    d     = a_sh[0] ^ b_sh[0] ^ bin;
    bout  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bin);
    r_nxt = {d, r_sh[WIDTH-1:1]};
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      diff_q   <= '0;
      cnt      <= '0;
      bin      <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_nxt;
          bin  <= bout;
          cnt  <= cnt + CW'(1);
          if (last) begin
            state    <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= r_nxt;
            borrow_q <= bout;
          end
        end
        // IDLE and DONE both accept a start, which gives back-to-back operation.
        default: begin
          if (bus.start) begin
            state  <= S_RUN;
            busy_q <= 1'b1;
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            r_sh   <= '0;
            bin    <= 1'b0;
            cnt    <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // The operand MSBs are shifted out during RUN, so keep copies for the final overflow test.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state != S_RUN) begin
      if (bus.start) begin
        a_msb <= bus.a[WIDTH-1];
        b_msb <= bus.b[WIDTH-1];
      end
    end else if (last) begin
      ovf_q <= (a_msb != b_msb) && (d != a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule
